acf_axil_regs: RTL and testbench



---
 rtl/acf_axil_regs.sv | 216 +++++++++++++++++++++
 tb/tb_acf_axil_regs.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acf_axil_regs.sv
// AXI4-Lite register block for the ACF core: holds maxCnt/CE/initTx and a read-only
// capture buffer of the 64-bit ACF elements, exposed as pairs of 32-bit words.
module acf_axil_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_SIZE   = 35,
  parameter int NUM_EL     = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [CNT_SIZE-1:0]   maxCnt,
  output logic                  CE,
  output logic                  initTx,
  input  logic                  cntFinished,
  input  logic                  wrEn,
  input  logic [63:0]           acfEl
);

  localparam int HI_W  = CNT_SIZE - 32;
  localparam int IDX_W = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
  localparam int PTR_W = $clog2(NUM_EL + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  ready_en;
  logic                  aw_pending;
  logic                  w_pending;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  commit;
  logic                  wr_hit;
  logic [7:0]            wr_off;
  logic [31:0]           lo_merged;
  logic [31:0]           hi_merged;
  logic [31:0]           maxcnt_lo;
  logic [HI_W-1:0]       maxcnt_hi;
  logic                  ce;
  logic                  init_tx;
  logic [63:0]           el_buf [NUM_EL];
  logic [PTR_W-1:0]      wptr;
  logic                  full;
  logic                  el_write;
  logic                  rd_hit;
  logic [7:0]            rd_off;
  logic [4:0]            rd_slot;
  logic [63:0]           rd_el;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Word-aligned register offsets plus the element window; anything above bit 7 is an error.
  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] addr);
    logic [8:0] off;
    off = {1'b0, addr[7:0]};
    if (addr[ADDR_WIDTH-1:8] != '0 || off[1:0] != 2'b00) return 1'b0;
    else if (off <= 9'h010) return 1'b1;
    else if (off >= 9'h040 && off < 9'(64 + 8 * NUM_EL)) return 1'b1;
    else return 1'b0;
  endfunction

  assign commit    = aw_pending && w_pending;
  assign wr_hit    = addr_mapped(wr_addr);
  assign wr_off    = wr_addr[7:0];
  assign lo_merged = merge_bytes(maxcnt_lo, wr_data, wr_strb);
  assign hi_merged = merge_bytes(32'(maxcnt_hi), wr_data, wr_strb);

  assign s_awready = ready_en && !aw_pending && !s_bvalid;
  assign s_wready  = ready_en && !w_pending && !s_bvalid;
  assign s_arready = ready_en && !s_rvalid;

  assign maxCnt = {maxcnt_hi, maxcnt_lo};
  assign CE     = ce;
  assign initTx = init_tx;

  // Write address/data capture and response generation.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ready_en   <= 1'b0;
      aw_pending <= 1'b0;
      w_pending  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 32'h0;
      wr_strb    <= 4'h0;
      s_bvalid   <= 1'b0;
      s_bresp    <= 2'b00;
    end else begin
      ready_en <= 1'b1;
      if (s_awvalid && s_awready) begin
        aw_pending <= 1'b1;
        wr_addr    <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        w_pending <= 1'b1;
        wr_data   <= s_wdata;
        wr_strb   <= s_wstrb;
      end
      if (commit) begin
        aw_pending <= 1'b0;
        w_pending  <= 1'b0;
        s_bvalid   <= 1'b1;
        s_bresp    <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Control registers; writes to read-only offsets fall through to default and are dropped.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      maxcnt_lo <= 32'h0;
      maxcnt_hi <= '0;
      ce        <= 1'b0;
      init_tx   <= 1'b0;
    end else begin
      init_tx <= 1'b0;
      if (commit && wr_hit) begin
        case (wr_off)
          8'h00:   maxcnt_lo <= lo_merged;
          8'h04:   if (wr_strb[0]) ce <= wr_data[0];
          8'h08:   init_tx <= wr_strb[0] && wr_data[0];
          8'h0C:   maxcnt_hi <= hi_merged[HI_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign full     = (wptr == PTR_W'(NUM_EL));
  assign el_write = wrEn && !full && !init_tx;

  // Capture pointer: an initTx pulse restarts capture and wins over a same-cycle element.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
    end else if (init_tx) begin
      wptr <= '0;
    end else if (el_write) begin
      wptr <= wptr + PTR_W'(1);
    end
  end

  // Element storage is never cleared so stale slots keep their last data.
  always_ff @(posedge sys_clk) begin
    if (el_write) el_buf[wptr[IDX_W-1:0]] <= acfEl;
  end

  // Read data mux for the address currently on the AR channel.
  always_comb begin
    rd_hit  = addr_mapped(s_araddr);
    rd_off  = s_araddr[7:0];
    rd_slot = rd_off[7:3] - 5'd8;
    rd_el   = el_buf[rd_slot[IDX_W-1:0]];
    rd_word = 32'h0;
    if (!rd_hit) begin
      rd_word = 32'h0;
    end else if (rd_off[7:6] != 2'b00) begin
      rd_word = rd_off[2] ? rd_el[63:32] : rd_el[31:0];
    end else begin
      case (rd_off)
        8'h00:   rd_word = maxcnt_lo;
        8'h04:   rd_word = {31'h0, ce};
        8'h0C:   rd_word = 32'(maxcnt_hi);
        8'h10:   rd_word = {16'h0, 8'(wptr), 6'h0, full, cntFinished};
        default: rd_word = 32'h0;
      endcase
    end
  end

  // Read response register; data is held stable until the master accepts it.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
      s_rresp  <= 2'b00;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_word;
      s_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  assign unused_ok = ^{s_awprot, s_arprot, hi_merged, rd_slot};

endmodule

// File: tb/tb_acf_axil_regs.sv
// Self-checking bench for acf_axil_regs: directed AXI-Lite steps followed by random traffic
// compared against a register-map level model of the block.
module tb_acf_axil_regs;
  localparam int NUM_EL   = 16;
  localparam int CNT_SIZE = 35;

  logic                sys_clk = 1'b0;
  logic                rst = 1'b0;
  logic [31:0]         s_awaddr = 32'h0;
  logic [2:0]          s_awprot = 3'h0;
  logic                s_awvalid = 1'b0;
  logic                s_awready;
  logic [31:0]         s_wdata = 32'h0;
  logic [3:0]          s_wstrb = 4'h0;
  logic                s_wvalid = 1'b0;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready = 1'b0;
  logic [31:0]         s_araddr = 32'h0;
  logic [2:0]          s_arprot = 3'h0;
  logic                s_arvalid = 1'b0;
  logic                s_arready;
  logic [31:0]         s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready = 1'b0;
  logic [CNT_SIZE-1:0] maxCnt;
  logic                CE;
  logic                initTx;
  logic                cntFinished = 1'b0;
  logic                wrEn = 1'b0;
  logic [63:0]         acfEl = 64'h0;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [63:0] m_max;
  logic        m_ce;
  int          m_cnt;
  logic [63:0] m_buf [NUM_EL];
  bit          m_wr  [NUM_EL];

  logic [CNT_SIZE-1:0] obs_max;
  logic obs_ce, obs_tx, obs_tx_next;

  always #5 sys_clk = ~sys_clk;

  acf_axil_regs #(.ADDR_WIDTH(32), .CNT_SIZE(CNT_SIZE), .NUM_EL(NUM_EL)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .maxCnt(maxCnt), .CE(CE), .initTx(initTx),
    .cntFinished(cntFinished), .wrEn(wrEn), .acfEl(acfEl)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_mapped(input logic [31:0] a);
    if (a > 32'hFF || a % 4 != 0) return 1'b0;
    return (a <= 32'h10) || (a >= 32'h40 && a < 32'h40 + 8 * NUM_EL);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic pulse);
    pulse = 1'b0;
    resp  = m_mapped(a) ? 2'b00 : 2'b10;
    if (a == 32'h00) m_max[31:0] = byte_merge(m_max[31:0], d, s);
    if (a == 32'h0C) begin
      m_max[63:32] = byte_merge(m_max[63:32], d, s);
      m_max = m_max & ((64'd1 << CNT_SIZE) - 64'd1);
    end
    if (a == 32'h04 && s[0]) m_ce = d[0];
    if (a == 32'h08 && s[0] && d[0]) begin
      pulse = 1'b1;
      m_cnt = 0;
    end
  endtask

  function automatic logic [33:0] model_read(input logic [31:0] a);
    logic [63:0] e;
    logic [31:0] v;
    if (!m_mapped(a)) return {2'b10, 32'h0};
    if (a >= 32'h40) begin
      e = m_buf[(a - 32'h40) / 8];
      return {2'b00, (a % 8 == 4) ? e[63:32] : e[31:0]};
    end
    v = 32'h0;
    if (a == 32'h00) v = m_max[31:0];
    if (a == 32'h04) v = {31'h0, m_ce};
    if (a == 32'h0C) v = m_max[63:32];
    if (a == 32'h10) v = (32'(m_cnt) << 8) | ((m_cnt == NUM_EL) ? 32'h2 : 32'h0) | {31'h0, cntFinished};
    return {2'b00, v};
  endfunction

  task automatic model_push(input logic [63:0] d);
    if (m_cnt < NUM_EL) begin
      m_buf[m_cnt] = d;
      m_wr[m_cnt]  = 1'b1;
      m_cnt++;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit inject, input logic [63:0] inj_el, output logic [1:0] resp);
    int n;
    logic aw_fire, w_fire;
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    s_bready = 1'b1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 20) begin
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      @(negedge sys_clk);
      n++;
      if (aw_fire) s_awvalid = 1'b0;
      if (w_fire) s_wvalid = 1'b0;
    end
    check("wr_handshake_cycles", 64'(n), 64'd1);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check("wr_bvalid_latency", 64'(n), 64'd1);
    resp = s_bresp; obs_max = maxCnt; obs_ce = CE; obs_tx = initTx;
    if (inject) begin
      wrEn = 1'b1; acfEl = inj_el;
    end
    @(negedge sys_clk);
    wrEn = 1'b0;
    obs_tx_next = initTx;
    s_bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit inject, input logic [63:0] inj_el);
    logic [1:0] r, er;
    logic ep;
    axi_write(a, d, s, inject, inj_el, r);
    model_write(a, d, s, er, ep);
    check("wr_bresp", 64'(r), 64'(er));
    check("wr_maxcnt", 64'(obs_max), m_max);
    check("wr_ce", 64'(obs_ce), 64'(m_ce));
    check("wr_inittx", 64'(obs_tx), 64'(ep));
    check("wr_inittx_next", 64'(obs_tx_next), 64'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic fire;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (s_arvalid && n < 20) begin
      fire = s_arvalid && s_arready;
      @(negedge sys_clk);
      n++;
      if (fire) s_arvalid = 1'b0;
    end
    s_arvalid = 1'b0;
    check("rd_rvalid_latency", {63'(n), s_rvalid}, {63'd1, 1'b1});
    data = s_rdata; resp = s_rresp;
    @(negedge sys_clk);
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] e;
    e = model_read(a);
    axi_read(a, d, r);
    check({tag, "_data"}, 64'(d), 64'(e[31:0]));
    check({tag, "_resp"}, 64'(r), 64'(e[33:32]));
  endtask

  task automatic push(input logic [63:0] d);
    wrEn = 1'b1; acfEl = d;
    @(negedge sys_clk);
    wrEn = 1'b0;
    model_push(d);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] a;
    logic [31:0] wr_addrs [9];
    int sl;
    wr_addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h40, 32'h14, 32'h100, 32'h3C};
    m_max = 64'h0; m_ce = 1'b0; m_cnt = 0;
    for (int i = 0; i < NUM_EL; i++) m_wr[i] = 1'b0;

    // reset state
    repeat (3) @(negedge sys_clk);
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_wready", 64'(s_wready), 64'd0);
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_valids", {62'h0, s_bvalid, s_rvalid}, 64'd0);
    check("rst_resp_data", {30'h0, s_bresp, s_rresp, s_rdata}, 64'd0);
    check("rst_outputs", {27'h0, CE, initTx, maxCnt}, 64'd0);
    rst = 1'b1;
    @(negedge sys_clk);
    check("rel_readies", {61'h0, s_awready, s_wready, s_arready}, 64'h7);

    // maxCnt programming and readback
    do_write(32'h00, 32'd10000, 4'hF, 1'b0, 64'h0);
    check("tp_maxcnt_10000", 64'(obs_max), 64'd10000);
    do_write(32'h0C, 32'h0, 4'hF, 1'b0, 64'h0);
    do_read(32'h00, "tp_rd_maxcnt_lo");

    // CE and initTx pulse
    do_write(32'h04, 32'h1, 4'hF, 1'b0, 64'h0);
    check("tp_ce_set", 64'(CE), 64'd1);
    do_write(32'h08, 32'h1, 4'hF, 1'b0, 64'h0);
    do_read(32'h08, "tp_rd_inittx");
    do_read(32'h04, "tp_rd_ctrl");

    // W three cycles ahead of AW, bready held low for four cycles
    s_bready = 1'b0;
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    check("wfirst_wready", 64'(s_wready), 64'd1);
    @(negedge sys_clk);
    s_wvalid = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      check("wfirst_wait", {62'h0, s_wready, s_bvalid}, 64'd0);
    end
    s_awaddr = 32'h00; s_awvalid = 1'b1;
    check("wfirst_awready", 64'(s_awready), 64'd1);
    @(negedge sys_clk);
    s_awvalid = 1'b0;
    check("wfirst_no_early_commit", 64'(s_bvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("wfirst_hold", {61'h0, s_bvalid, s_awready, s_wready}, 64'h4);
    end
    check("wfirst_maxcnt", 64'(maxCnt[31:0]), 64'h1234_5678);
    m_max[31:0] = 32'h1234_5678;
    s_bready = 1'b1;
    @(negedge sys_clk);
    check("wfirst_bvalid_cleared", 64'(s_bvalid), 64'd0);
    s_bready = 1'b0;
    do_read(32'h00, "wfirst_rd");

    // fill the capture buffer past its end
    for (int i = 0; i < NUM_EL + 2; i++) push(64'(i) * 64'h1_0000_0001);
    axi_read(32'h10, d, r);
    check("tp_status_full", 64'(d), 64'h1002);
    do_read(32'h10, "rd_status");
    do_read(32'h48, "rd_el1_lo");
    do_read(32'h4C, "rd_el1_hi");
    do_read(32'hB8, "rd_el15_lo");
    do_read(32'hBC, "rd_el15_hi");

    // initTx and wrEn in the same cycle: element discarded
    do_write(32'h08, 32'h1, 4'h1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D);
    check("tp_clear_pulse", 64'(obs_tx), 64'd1);
    axi_read(32'h10, d, r);
    check("tp_status_cleared", 64'(d), 64'h0);
    push(64'hCAFE_0000_0000_0042);
    do_read(32'h40, "rd_el0_new_lo");
    do_read(32'h44, "rd_el0_new_hi");
    do_read(32'h48, "rd_el1_stale");

    // error responses and strobes
    do_read(32'h20, "rd_unmapped");
    do_read(32'h100, "rd_high_addr");
    do_read(32'hC0, "rd_past_elements");
    do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 64'h0);
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, 64'h0);
    do_write(32'h00, 32'h0, 4'hF, 1'b0, 64'h0);
    do_write(32'h00, 32'hAABB_CCDD, 4'h2, 1'b0, 64'h0);
    axi_read(32'h00, d, r);
    check("tp_partial_strobe", 64'(d), 64'h0000_CC00);
    do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0, 64'h0);
    do_read(32'h0C, "rd_maxcnt_hi_mask");
    do_write(32'h08, 32'h1, 4'h2, 1'b0, 64'h0);

    // random traffic against the model
    for (int k = 0; k < 80; k++) begin
      cntFinished = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: push({$urandom, $urandom});
        1: do_write(wr_addrs[$urandom_range(0, 8)], $urandom, 4'($urandom_range(0, 15)), 1'b0, 64'h0);
        default: begin
          sl = $urandom_range(0, 9);
          if (sl < 5) a = 32'(sl) * 32'd4;
          else if (sl < 8) begin
            sl = $urandom_range(0, NUM_EL - 1);
            a = m_wr[sl] ? 32'h40 + 32'(sl) * 32'd8 + 32'($urandom_range(0, 1)) * 32'd4 : 32'h10;
          end else if (sl == 8) a = 32'hC4;
          else a = 32'h1_0010;
          do_read(a, "rand_rd");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
